// File: rtl/fp_align_addsub_if.sv
// Operand/result handshake bundle for the FP add/sub alignment front end.
// Both channels use the same valid/ready rule: a transfer happens on a rising
// clock edge where valid and ready are both high; the sender holds its payload
// stable while valid is high and ready is low, and ready may depend
// combinationally on the far side's ready.
interface fp_align_addsub_if #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 10,
  parameter int OUT_W  = FRAC_W + 2
);
  // operand channel
  logic              in_valid;
  logic              in_ready;
  logic              op_sub;
  logic              sign_a;
  logic [EXP_W-1:0]  exp_a;
  logic [FRAC_W-1:0] frac_a;
  logic              sign_b;
  logic [EXP_W-1:0]  exp_b;
  logic [FRAC_W-1:0] frac_b;
  // result channel
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [OUT_W-1:0]  out_mantissa;
  logic              out_zero;

  // operand producer / result consumer side
  modport master (
    output in_valid, op_sub, sign_a, exp_a, frac_a, sign_b, exp_b, frac_b,
    output out_ready,
    input  in_ready,
    input  out_valid, out_sign, out_exp, out_mantissa, out_zero
  );

  // the datapath block itself
  modport slave (
    input  in_valid, op_sub, sign_a, exp_a, frac_a, sign_b, exp_b, frac_b,
    input  out_ready,
    output in_ready,
    output out_valid, out_sign, out_exp, out_mantissa, out_zero
  );
endinterface

// File: rtl/fp_align_addsub.sv
// Floating-point add/subtract front end: exponent compare, operand swap,
// right-alignment of the smaller mantissa, then magnitude add/subtract.
// Produces an unnormalized magnitude plus the larger exponent for the
// downstream leading-one normalizer.
//
// Pipeline: s1 captures the operand pair on accept; compare/align runs from
// s1 into the s2 register; add/sub runs from s2 into the output register.
// An operand accepted at edge N is visible on out_valid after edge N+2.
// A stalled output freezes everything behind it; each register loads only
// when it is empty or the register after it is taking its contents.
module fp_align_addsub #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 10,
  parameter int OUT_W  = FRAC_W + 2
) (
  input  logic          clk,
  input  logic          rst_n,
  fp_align_addsub_if.slave bus
);
  localparam int MANT_W = FRAC_W + 1;

  typedef struct packed {
    logic              op_sub;
    logic              sign_a;
    logic [EXP_W-1:0]  exp_a;
    logic [FRAC_W-1:0] frac_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_b;
    logic [FRAC_W-1:0] frac_b;
  } op_t;

  typedef struct packed {
    logic              sign_big;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp_big;
    logic [MANT_W-1:0] mant_big;
    logic [MANT_W-1:0] mant_small;
  } align_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp_v;
    logic [OUT_W-1:0]  mant;
    logic              zero;
  } res_t;

  logic   s1_valid_q, s1_valid_d;
  logic   s2_valid_q, s2_valid_d;
  logic   out_valid_q, out_valid_d;
  op_t    s1_op_q, s1_op_d;
  align_t s2_al_q, s2_al_d;
  res_t   out_res_q, out_res_d;

  logic   out_load_ok, s2_load_ok, s1_load_ok;

  align_t            align_c;
  res_t              res_c;
  logic [MANT_W-1:0] mant_a, mant_b, mant_small;
  logic [EXP_W-1:0]  exp_small, exp_diff;
  logic              eff_sign_b, sign_small, a_is_big;
  logic [OUT_W-1:0]  big_ext, small_ext, mag;

  // Stall chain: a register may load when empty or when its successor drains it.
  always_comb begin
    out_load_ok = !out_valid_q || bus.out_ready;
    s2_load_ok  = !s2_valid_q  || out_load_ok;
    s1_load_ok  = !s1_valid_q  || s2_load_ok;
  end

  // Compare exponents, pick the larger operand, right-align the smaller one.
  always_comb begin
    align_c    = '0;
    mant_a     = {1'b1, s1_op_q.frac_a};
    mant_b     = {1'b1, s1_op_q.frac_b};
    eff_sign_b = s1_op_q.sign_b ^ s1_op_q.op_sub;
    // full tie keeps A as the big operand
    a_is_big   = (s1_op_q.exp_a > s1_op_q.exp_b) ||
                 ((s1_op_q.exp_a == s1_op_q.exp_b) && (mant_a >= mant_b));
    exp_small  = '0;
    mant_small = '0;
    sign_small = 1'b0;
    if (a_is_big) begin
      align_c.exp_big  = s1_op_q.exp_a;
      align_c.sign_big = s1_op_q.sign_a;
      align_c.mant_big = mant_a;
      exp_small        = s1_op_q.exp_b;
      mant_small       = mant_b;
      sign_small       = eff_sign_b;
    end else begin
      align_c.exp_big  = s1_op_q.exp_b;
      align_c.sign_big = eff_sign_b;
      align_c.mant_big = mant_b;
      exp_small        = s1_op_q.exp_a;
      mant_small       = mant_a;
      sign_small       = s1_op_q.sign_a;
    end
    exp_diff = align_c.exp_big - exp_small;
    // plain truncation: no guard/sticky bits are kept
    align_c.mant_small = (exp_diff >= EXP_W'(MANT_W)) ? '0 : (mant_small >> exp_diff);
    align_c.eff_sub    = align_c.sign_big ^ sign_small;
  end

  // Add or subtract the aligned magnitudes; an exact zero gets a clean +0 encoding.
  always_comb begin
    res_c     = '0;
    big_ext   = OUT_W'(s2_al_q.mant_big);
    small_ext = OUT_W'(s2_al_q.mant_small);
    // big >= small after the swap, so the difference never wraps
    mag        = s2_al_q.eff_sub ? (big_ext - small_ext) : (big_ext + small_ext);
    res_c.mant = mag;
    res_c.zero = (mag == '0);
    if (!res_c.zero) begin
      res_c.sign  = s2_al_q.sign_big;
      res_c.exp_v = s2_al_q.exp_big;
    end
  end

  // Next-state for valid flags and payload registers; payload holds unless loading.
  always_comb begin
    s1_valid_d  = s1_load_ok  ? bus.in_valid : s1_valid_q;
    s2_valid_d  = s2_load_ok  ? s1_valid_q   : s2_valid_q;
    out_valid_d = out_load_ok ? s2_valid_q   : out_valid_q;
    s1_op_d     = s1_op_q;
    s2_al_d     = s2_al_q;
    out_res_d   = out_res_q;
    if (s1_load_ok && bus.in_valid) begin
      s1_op_d.op_sub = bus.op_sub;
      s1_op_d.sign_a = bus.sign_a;
      s1_op_d.exp_a  = bus.exp_a;
      s1_op_d.frac_a = bus.frac_a;
      s1_op_d.sign_b = bus.sign_b;
      s1_op_d.exp_b  = bus.exp_b;
      s1_op_d.frac_b = bus.frac_b;
    end
    if (s2_load_ok && s1_valid_q) s2_al_d = align_c;
    if (out_load_ok && s2_valid_q) out_res_d = res_c;
  end

  // Pipeline registers; reset discards all in-flight data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      s1_op_q     <= '0;
      s2_al_q     <= '0;
      out_res_q   <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_valid_q <= out_valid_d;
      s1_op_q     <= s1_op_d;
      s2_al_q     <= s2_al_d;
      out_res_q   <= out_res_d;
    end
  end

  assign bus.in_ready     = s1_load_ok;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_sign     = out_res_q.sign;
  assign bus.out_exp      = out_res_q.exp_v;
  assign bus.out_mantissa = out_res_q.mant;
  assign bus.out_zero     = out_res_q.zero;
endmodule

// File: tb/tb_fp_align_addsub.sv
// Bench for fp_align_addsub: directed vectors with hand-derived results,
// randomized vectors against an integer reference model, output back-pressure,
// and asynchronous reset in the middle of a full pipe.
module tb_fp_align_addsub;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 10;
  localparam int OUT_W  = 12;
  localparam int RES_W  = 1 + EXP_W + OUT_W + 1;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_miss;
  int   n_waits;

  logic [RES_W-1:0] exp_q[$];

  fp_align_addsub_if #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) bus ();

  fp_align_addsub #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .OUT_W(OUT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [RES_W-1:0] pack_res(input logic s, input logic [7:0] e,
                                                 input logic [11:0] m, input logic z);
    return {s, e, m, z};
  endfunction

  // Integer reference: order operands by (exp, mantissa), align, add/sub.
  function automatic logic [RES_W-1:0] model_res(input logic sub, input logic sa,
      input logic [7:0] ea, input logic [9:0] fa, input logic sb,
      input logic [7:0] eb, input logic [9:0] fb);
    int ma, mb, ka, kb, mbig, msm, ebig, esm, d, r;
    logic sbig, ssm;
    ma = 1024 + int'(fa);
    mb = 1024 + int'(fb);
    ka = int'(ea) * 2048 + ma;
    kb = int'(eb) * 2048 + mb;
    if (ka >= kb) begin
      ebig = int'(ea); mbig = ma; sbig = sa;
      esm  = int'(eb); msm  = mb; ssm  = sb ^ sub;
    end else begin
      ebig = int'(eb); mbig = mb; sbig = sb ^ sub;
      esm  = int'(ea); msm  = ma; ssm  = sa;
    end
    d = ebig - esm;
    if (d > 10) msm = 0;
    else msm = msm >> d;
    r = (sbig != ssm) ? (mbig - msm) : (mbig + msm);
    if (r == 0) return pack_res(1'b0, 8'd0, 12'd0, 1'b1);
    return pack_res(sbig, 8'(ebig), 12'(r), 1'b0);
  endfunction

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 right after the accepting edge
  // with in_valid still high so the next call can follow back-to-back.
  task automatic drive_op(input logic sub, input logic sa, input logic [7:0] ea,
                          input logic [9:0] fa, input logic sb, input logic [7:0] eb,
                          input logic [9:0] fb, input logic [RES_W-1:0] want);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.op_sub   = sub;
    bus.sign_a   = sa;
    bus.exp_a    = ea;
    bus.frac_a   = fa;
    bus.sign_b   = sb;
    bus.exp_b    = eb;
    bus.frac_b   = fb;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(want);
        done = 1'b1;
      end else begin
        n_waits++;
      end
      @(posedge clk);
      #1;
    end
    if (!done) check_eq("accept_timeout", 32'(done), 32'd1);
  endtask

  task automatic drive_rand();
    logic sub, sa, sb;
    logic [7:0] ea, eb;
    logic [9:0] fa, fb;
    sub = 1'($urandom_range(0, 1));
    sa  = 1'($urandom_range(0, 1));
    sb  = 1'($urandom_range(0, 1));
    ea  = 8'($urandom_range(118, 136));
    eb  = ($urandom_range(0, 3) == 0) ? ea : 8'($urandom_range(118, 136));
    fa  = 10'($urandom_range(0, 1023));
    fb  = ($urandom_range(0, 4) == 0) ? fa : 10'($urandom_range(0, 1023));
    drive_op(sub, sa, ea, fa, sb, eb, fb, model_res(sub, sa, ea, fa, sb, eb, fb));
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [RES_W-1:0] prev_res;
  logic             prev_stalled;

  // Outputs are sampled at negedge; a result seen with out_ready high is
  // the one transferred at the following rising edge.
  always @(negedge clk) begin
    logic [RES_W-1:0] cur;
    cur = {bus.out_sign, bus.out_exp, bus.out_mantissa, bus.out_zero};
    if (!rst_n) begin
      prev_stalled = 1'b0;
    end else begin
      if (bus.out_valid && !bus.out_ready && prev_stalled)
        check_eq("stall_hold", 32'(cur), 32'(prev_res));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check_eq("unexpected_out", 32'(exp_q.size()), 32'd1);
        else check_eq("result", 32'(cur), 32'(exp_q.pop_front()));
      end
      prev_stalled = bus.out_valid && !bus.out_ready;
      prev_res     = cur;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    bit stream_done;
    n_vec = 0; n_miss = 0; n_waits = 0;
    prev_stalled = 1'b0; prev_res = '0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op_sub = 1'b0; bus.sign_a = 1'b0; bus.exp_a = '0; bus.frac_a = '0;
    bus.sign_b = 1'b0; bus.exp_b = '0; bus.frac_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_out_sign",  32'(bus.out_sign), 32'd0);
    check_eq("rst_out_exp",   32'(bus.out_exp), 32'd0);
    check_eq("rst_out_mant",  32'(bus.out_mantissa), 32'd0);
    check_eq("rst_out_zero",  32'(bus.out_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // +1.0 + +1.0, then latency from an empty pipe
    drive_op(1'b0, 1'b0, 8'd127, 10'h000, 1'b0, 8'd127, 10'h000, pack_res(1'b0, 8'd127, 12'h800, 1'b0));
    idle();
    @(negedge clk); check_eq("lat_edge0", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check_eq("lat_edge1", 32'(bus.out_valid), 32'd0);
    @(negedge clk); check_eq("lat_edge2", 32'(bus.out_valid), 32'd1);
    @(posedge clk); #1;

    // directed vectors, back-to-back
    drive_op(1'b1, 1'b0, 8'd127, 10'h200, 1'b0, 8'd127, 10'h000, pack_res(1'b0, 8'd127, 12'h200, 1'b0));
    drive_op(1'b1, 1'b0, 8'd127, 10'h000, 1'b0, 8'd127, 10'h200, pack_res(1'b1, 8'd127, 12'h200, 1'b0));
    drive_op(1'b0, 1'b0, 8'd140, 10'h000, 1'b0, 8'd127, 10'h3FF, pack_res(1'b0, 8'd140, 12'h400, 1'b0));
    drive_op(1'b0, 1'b0, 8'd140, 10'h000, 1'b0, 8'd137, 10'h3FF, pack_res(1'b0, 8'd140, 12'h4FF, 1'b0));
    drive_op(1'b0, 1'b0, 8'd137, 10'h000, 1'b0, 8'd127, 10'h3FF, pack_res(1'b0, 8'd137, 12'h401, 1'b0));
    drive_op(1'b0, 1'b0, 8'd138, 10'h000, 1'b0, 8'd127, 10'h3FF, pack_res(1'b0, 8'd138, 12'h400, 1'b0));
    drive_op(1'b1, 1'b1, 8'd130, 10'h155, 1'b1, 8'd130, 10'h155, pack_res(1'b0, 8'd0, 12'h000, 1'b1));
    drive_op(1'b0, 1'b1, 8'd90,  10'h3FF, 1'b1, 8'd90,  10'h3FF, pack_res(1'b1, 8'd90, 12'hFFE, 1'b0));
    drive_op(1'b0, 1'b0, 8'd100, 10'h000, 1'b1, 8'd101, 10'h000, pack_res(1'b1, 8'd101, 12'h200, 1'b0));
    idle();
    repeat (4) @(posedge clk);
    #1;

    // 8 back-to-back with out_ready low during cycles 3..6
    n_waits = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) drive_rand();
        idle();
      end
      begin
        for (int i = 0; i < 11; i++) begin
          bus.out_ready = !(i >= 3 && i <= 6);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join
    check_eq("in_ready_dropped", 32'(n_waits > 0), 32'd1);
    repeat (5) @(posedge clk);
    #1;

    // fill the pipe under back-pressure, then reset asynchronously
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) drive_rand();
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("async_rst_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("no_stale", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk); #1;
    drive_op(1'b0, 1'b0, 8'd127, 10'h000, 1'b0, 8'd127, 10'h000, pack_res(1'b0, 8'd127, 12'h800, 1'b0));
    drive_op(1'b1, 1'b0, 8'd127, 10'h200, 1'b0, 8'd127, 10'h000, pack_res(1'b0, 8'd127, 12'h200, 1'b0));
    idle();

    // randomized traffic with random back-pressure
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          drive_rand();
          if ($urandom_range(0, 3) == 0) begin
            idle();
            @(posedge clk); #1;
          end
        end
        idle();
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          bus.out_ready = 1'($urandom_range(0, 2) != 0);
          @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
      end
    join

    // drain
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    check_eq("final_idle",  32'(bus.out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/fp_align_addsub.md
Name: fp_align_addsub

Overview:
- Two-stage pipelined front end of the floating-point add/subtract datapath.
- Compares exponents, swaps operands, right-aligns the smaller mantissa and adds or subtracts the magnitudes.
- Produces an unnormalized 12-bit magnitude plus the larger exponent for the downstream leading-one normalizer.
- Valid/ready handshake on input and output; back-pressure stalls the whole pipe.

Parameters:
- EXP_W, 8, exponent width (biased, unsigned).
- FRAC_W, 10, stored fraction width; hidden bit prepended internally, so MANT_W = FRAC_W+1 = 11.
- OUT_W, 12, output mantissa width = MANT_W+1 (bit 11 = carry).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts operands this cycle.
- op_sub  in  1  1 = A-B, 0 = A+B.
- sign_a  in  1  sign of A.
- exp_a  in  EXP_W  exponent of A.
- frac_a  in  FRAC_W  fraction of A.
- sign_b  in  1  sign of B.
- exp_b  in  EXP_W  exponent of B.
- frac_b  in  FRAC_W  fraction of B.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_sign  out  1  result sign.
- out_exp  out  EXP_W  larger operand exponent, pre-normalization.
- out_mantissa  out  OUT_W  unsigned result magnitude, unnormalized.
- out_zero  out  1  exact-zero result.

Behaviour:
- Reset, asynchronous, low: both stage valid flags = 0; out_valid = 0; out_sign = 0; out_exp = 0; out_mantissa = 0; out_zero = 0. in_ready = 1 after reset releases.
- Transfer happens when valid and ready are both high on a rising edge.
- Latency: accepted at edge N; result presented on out_valid after edge N+2. Throughput is 1 per cycle with no stall.
- Stall rule: stage 2 holds when out_valid && !out_ready.
  - Stage 1 advances when stage 2 is empty or advancing.
  - in_ready = !s1_valid || stage-1 advance. Combinational from out_ready; no skid buffer.
- Output registers hold stable while out_valid && !out_ready.
- Stage 1, compare/align:
  - Mantissa = {1'b1, frac}. exp = 0 is treated as a normal number; no denormals.
  - Effective sign of B: sign_b XOR op_sub.
  - Big = operand with larger exp. If exps are equal, big = larger mantissa; on full tie, big = A.
  - d = exp_big - exp_small, unsigned. Small mantissa is shifted right by d with truncation (no guard/sticky bits). If d >= MANT_W, the shifted value = 0.
  - Registered: exp_big, sign_big, eff_sub = sign_big XOR eff_sign_small, mant_big, mant_small_shifted.
- Stage 2, add/sub:
  - eff_sub = 0: out_mantissa = mant_big + mant_small, zero-extended to OUT_W. Carry lands in bit 11.
  - eff_sub = 1: out_mantissa = mant_big - mant_small. Never negative, by the swap rule. Bit 11 = 0.
  - out_exp = exp_big; out_sign = sign_big.
  - If out_mantissa = 0: out_zero = 1, out_sign forced to 0, out_exp forced to 0.
- No overflow or saturation handling on the exponent; the normalizer owns the exponent adjust.
- Reset mid-operation discards all in-flight data. The first output after reset comes only from operands accepted after release.
- Simultaneous input accept and output drain in the same cycle with the pipe full: both transfers occur, no bubble, no loss.

Test Plan:
- A=+1.0 (exp 127, frac 0), B=+1.0, op_sub=0 -> out_mantissa=0x800, out_exp=127, out_sign=0, out_zero=0, valid exactly 2 cycles after accept.
- A=+1.5 (exp 127, frac 0x200), B=+1.0 (exp 127), op_sub=1 -> out_mantissa=0x200, out_exp=127, out_sign=0.
- A=+1.0 (exp 127), B=+1.5 (exp 127, frac 0x200), op_sub=1 -> swap: out_mantissa=0x200, out_exp=127, out_sign=1.
- A exp 140 frac 0, B exp 127 frac 0x3FF, op_sub=0 (d=13) -> out_mantissa=0x400, out_exp=140. With B exp 137 (d=3) instead -> out_mantissa=0x400+0xFF=0x4FF.
- A=B=exp 130 frac 0x155, op_sub=1 -> out_zero=1, out_mantissa=0, out_sign=0, out_exp=0.
- Stream 8 back-to-back ops with out_ready low for cycles 3-6 -> in_ready drops after the pipe fills; no result lost or duplicated; order preserved; outputs stable while stalled. Assert rst_n low mid-stream -> out_valid=0 immediately, asynchronously; no stale result after release.
